// File: rtl/tpu_pkg.sv
// tpu_pkg: shared instruction type, reset instruction and hold-class helper for the look-ahead queue
package tpu_pkg;
  localparam int OPCODE_WIDTH = 8;
  localparam int OPERAND_WIDTH = 24;
  typedef struct packed {
    logic [OPCODE_WIDTH-1:0]  opcode;
    logic [OPERAND_WIDTH-1:0] operand;
  } instr_type;
  localparam instr_type INIT_INSTR = '0;
  localparam logic [OPCODE_WIDTH-4:0] HOLD_PREFIX_DEFAULT = 5'b00001;
  function automatic logic is_hold_class(input instr_type instr, input logic [OPCODE_WIDTH-4:0] prefix);
    return instr.opcode[OPCODE_WIDTH-1:3] == prefix;
  endfunction
endpackage

// File: rtl/instr_ring_buffer.sv
// instr_ring_buffer: in-order instruction storage (push/pop, head view, entry count); clk, rst async active-high
module instr_ring_buffer
  import tpu_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  instr_type                  din,
  output instr_type                  head,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  instr_type mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count + CW'(push) - CW'(pop);
    end
  assign head = mem[rd_ptr];
endmodule

// File: rtl/look_ahead_queue.sv
// look_ahead_queue: holds weight-load instructions at the head until enough look-ahead, timeout or flush; ports: clk, rst, enable, instr_in/instr_write/instr_full (producer), flush, instr_busy/instr_out/instr_read (consumer), occupancy, hold_active, overflow
module look_ahead_queue
  import tpu_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int LOOKAHEAD = 1,
  parameter int HOLD_TIMEOUT = 16,
  parameter logic [OPCODE_WIDTH-4:0] HOLD_PREFIX = HOLD_PREFIX_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  instr_type                  instr_in,
  input  logic                       instr_write,
  output logic                       instr_full,
  input  logic                       flush,
  input  logic                       instr_busy,
  output instr_type                  instr_out,
  output logic                       instr_read,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic                       hold_active,
  output logic                       overflow
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int TW = $clog2(HOLD_TIMEOUT+2);
  logic [CW-1:0] count, count_next;
  logic [TW-1:0] timer;
  instr_type head, out_q;
  logic read_q, flush_mode, full, head_hold, timed_out, releasable, push, pop;
  instr_ring_buffer #(.DEPTH(DEPTH)) u_ring (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(instr_in), .head(head), .count(count)
  );
  always_comb begin
    full = count == CW'(DEPTH);
    head_hold = is_hold_class(head, HOLD_PREFIX);
    timed_out = HOLD_TIMEOUT > 0 && timer >= TW'(HOLD_TIMEOUT);
    releasable = count != '0 && (!head_hold || count > CW'(LOOKAHEAD) || flush || flush_mode || timed_out);
    hold_active = count != '0 && head_hold && !releasable;
    push = instr_write && enable && !full;
    pop = enable && !instr_busy && releasable;
    count_next = count + CW'(push) - CW'(pop);
    instr_full = full || !enable;
    occupancy = count;
    instr_out = instr_busy ? INIT_INSTR : out_q;
    instr_read = !instr_busy && read_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_q <= INIT_INSTR;
      read_q <= 1'b0;
      timer <= '0;
      flush_mode <= 1'b0;
      overflow <= 1'b0;
    end else if (enable) begin
      overflow <= overflow || (instr_write && full);
      flush_mode <= (flush_mode || (flush && count != '0)) && count_next != '0;
      if (!instr_busy) begin
        out_q <= pop ? head : INIT_INSTR;
        read_q <= pop;
        timer <= pop ? '0 : (hold_active && timer != '1) ? timer + TW'(1) : timer;
      end
    end
endmodule
